// File: rtl/apb_reg_completer.sv
// APB completer: register bank with programmable wait states, PSLVERR decode
// and a sticky flag for requester-side protocol violations.
module apb_reg_completer #(
    parameter int unsigned     ADDR = 32,
    parameter int unsigned     DATA = 32,
    parameter int unsigned     NREG = 8,
    parameter logic [ADDR-1:0] BASE = '0,
    parameter int unsigned     WAIT = 0,
    parameter logic [DATA-1:0] ID   = DATA'(32'hA5B0_0001)
) (
    input  logic                 pclk,
    input  logic                 preset,
    input  logic                 psel,
    input  logic                 penable,
    input  logic [2:0]           pprot,
    input  logic [ADDR-1:0]      paddr,
    input  logic                 pwrite,
    input  logic [DATA/8-1:0]    pstrb,
    input  logic [DATA-1:0]      pwdata,
    output logic [DATA-1:0]      prdata,
    output logic                 pslverr,
    output logic                 pready,
    output logic [NREG*DATA-1:0] reg_q,
    output logic                 proto_err,
    input  logic                 proto_clr
);

    localparam int unsigned   BYTES = DATA / 8;
    localparam int unsigned   ASH   = $clog2(BYTES);
    localparam int unsigned   IW    = $clog2(NREG);
    localparam logic [ADDR:0] LIMIT = {1'b0, BASE} + (ADDR+1)'(NREG * BYTES);

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] ACCESS = 1'b1;

    logic [0:0]       state;
    logic [3:0]       cnt;
    logic [ADDR-1:0]  cap_addr;
    logic             cap_write;
    logic             cap_priv;
    logic [BYTES-1:0] cap_strb;
    logic [DATA-1:0]  cap_wdata;
    logic [DATA-1:0]  regs [NREG];

    logic [ADDR-1:0]  offset;
    logic [IW-1:0]    idx;
    logic             in_range;
    logic             aligned;
    logic             err;
    logic             setup;
    logic             stray;
    logic             abort;
    logic             complete;
    logic             unused_prot;

    assign unused_prot = ^pprot[2:1];

    // Decode runs on the captured copy only; the live bus is ignored after setup.
    always_comb begin
        offset   = cap_addr - BASE;
        idx      = IW'(offset >> ASH);
        in_range = (cap_addr >= BASE) && ({1'b0, cap_addr} < LIMIT);
        aligned  = (cap_addr & ADDR'(BYTES - 1)) == '0;
        err      = !in_range || !aligned
                   || (cap_write && idx == '0)
                   || (cap_write && !cap_priv && idx == IW'(NREG - 1));
        setup    = (state == IDLE) && psel && !penable;
        stray    = (state == IDLE) && psel && penable;
        abort    = (state == ACCESS) && !(psel && penable);
        complete = !preset && (state == ACCESS) && psel && penable && (cnt == '0);
    end

    always_comb begin
        pready  = complete;
        pslverr = complete && err;
        prdata  = '0;
        if (complete && !err && !cap_write) begin
            prdata = regs[idx];
        end
    end

    always_ff @(posedge pclk) begin
        if (setup) begin
            cap_addr  <= paddr;
            cap_write <= pwrite;
            cap_priv  <= pprot[0];
            cap_strb  <= pstrb;
            cap_wdata <= pwdata;
        end
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            state     <= IDLE;
            cnt       <= '0;
            proto_err <= 1'b0;
            for (int unsigned i = 0; i < NREG; i++) begin
                regs[i]                <= (i == 0) ? ID : '0;
                reg_q[i*DATA +: DATA]  <= (i == 0) ? ID : '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (setup) begin
                        state <= ACCESS;
                        cnt   <= 4'(WAIT);
                    end
                end
                ACCESS: begin
                    if (abort) begin
                        state <= IDLE;
                    end else if (cnt != '0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        state <= IDLE;
                        if (cap_write && !err) begin
                            for (int unsigned b = 0; b < BYTES; b++) begin
                                if (cap_strb[b]) begin
                                    regs[idx][b*8 +: 8] <= cap_wdata[b*8 +: 8];
                                end
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase

            // A violation in the same cycle as proto_clr keeps the flag set.
            if (stray || abort) begin
                proto_err <= 1'b1;
            end else if (proto_clr) begin
                proto_err <= 1'b0;
            end

            for (int unsigned i = 0; i < NREG; i++) begin
                reg_q[i*DATA +: DATA] <= regs[i];
            end
        end
    end

endmodule

// File: tb/tb_apb_reg_completer.sv
// Bench for apb_reg_completer: four instances with WAIT = 0, 2, 3, 4, directed
// steps followed by random transfers checked against an array-based model.
module tb_apb_reg_completer;

    localparam int          NREG = 8;
    localparam logic [31:0] ID   = 32'hA5B0_0001;

    logic pclk = 1'b0;
    always #5 pclk = ~pclk;

    logic [3:0]   preset, psel, penable, pwrite, pslverr, pready, proto_err, proto_clr;
    logic [2:0]   pprot  [4];
    logic [31:0]  paddr  [4];
    logic [31:0]  pwdata [4];
    logic [31:0]  prdata [4];
    logic [3:0]   pstrb  [4];
    logic [255:0] reg_q  [4];

    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int unsigned W = (g == 0) ? 0 : (g == 1) ? 2 : (g == 2) ? 3 : 4;
        apb_reg_completer #(.WAIT(W)) u_dut (
            .pclk      (pclk),
            .preset    (preset[g]),
            .psel      (psel[g]),
            .penable   (penable[g]),
            .pprot     (pprot[g]),
            .paddr     (paddr[g]),
            .pwrite    (pwrite[g]),
            .pstrb     (pstrb[g]),
            .pwdata    (pwdata[g]),
            .prdata    (prdata[g]),
            .pslverr   (pslverr[g]),
            .pready    (pready[g]),
            .reg_q     (reg_q[g]),
            .proto_err (proto_err[g]),
            .proto_clr (proto_clr[g])
        );
    end

    logic [31:0] m_regs [4][NREG];
    logic        m_perr [4];
    int          checks = 0;
    int          errors = 0;

    function automatic int wait_of(input int k);
        case (k)
            0:       return 0;
            1:       return 2;
            2:       return 3;
            default: return 4;
        endcase
    endfunction

    task automatic chkb(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic chkw(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic chkq(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%064h expected=%064h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset(input int k);
        for (int i = 0; i < NREG; i++) m_regs[k][i] = (i == 0) ? ID : 32'h0;
        m_perr[k] = 1'b0;
    endfunction

    function automatic logic [255:0] model_flat(input int k);
        logic [255:0] f;
        for (int i = 0; i < NREG; i++) f[i*32 +: 32] = m_regs[k][i];
        return f;
    endfunction

    // Applies one transfer to the model; returns expected pslverr and prdata.
    function automatic void model_access(input int k, input logic [31:0] addr, input logic wr,
                                         input logic [2:0] prot, input logic [3:0] strb,
                                         input logic [31:0] wd, output logic e, output logic [31:0] rd);
        int unsigned ix;
        ix = addr / 4;
        e  = (addr >= 32'(NREG * 4)) || (addr % 4 != 0) || (wr && ix == 0)
             || (wr && ix == NREG - 1 && !prot[0]);
        rd = 32'h0;
        if (!e && !wr) rd = m_regs[k][ix];
        if (!e && wr)
            for (int b = 0; b < 4; b++)
                if (strb[b]) m_regs[k][ix][b*8 +: 8] = wd[b*8 +: 8];
    endfunction

    // Starts and ends 1 time unit after a rising edge.
    task automatic transfer(input int k, input logic [31:0] addr, input logic wr,
                            input logic [2:0] prot, input logic [3:0] strb,
                            input logic [31:0] wd, input string tag);
        logic        e;
        logic [31:0] r;
        int          w;
        w = wait_of(k);
        model_access(k, addr, wr, prot, strb, wd, e, r);
        psel[k] = 1'b1; penable[k] = 1'b0;
        paddr[k] = addr; pwrite[k] = wr; pprot[k] = prot; pstrb[k] = strb; pwdata[k] = wd;
        @(negedge pclk);
        chkb({tag, ".setup_pready"}, pready[k], 1'b0);
        @(posedge pclk); #1;
        penable[k] = 1'b1;
        for (int c = 0; c <= w; c++) begin
            @(negedge pclk);
            chkb({tag, ".pready"}, pready[k], c == w);
            chkb({tag, ".pslverr"}, pslverr[k], (c == w) ? e : 1'b0);
            chkw({tag, ".prdata"}, prdata[k], (c == w) ? r : 32'h0);
            @(posedge pclk); #1;
        end
        psel[k] = 1'b0; penable[k] = 1'b0;
    endtask

    task automatic idle_check(input int k, input string tag);
        @(posedge pclk); #1;
        @(negedge pclk);
        chkb({tag, ".idle_pready"}, pready[k], 1'b0);
        chkb({tag, ".idle_pslverr"}, pslverr[k], 1'b0);
        chkw({tag, ".idle_prdata"}, prdata[k], 32'h0);
        chkq({tag, ".reg_q"}, reg_q[k], model_flat(k));
        chkb({tag, ".proto_err"}, proto_err[k], m_perr[k]);
        @(posedge pclk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        preset = '1; psel = '0; penable = '0; pwrite = '0; proto_clr = '0;
        for (int k = 0; k < 4; k++) begin
            pprot[k] = '0; paddr[k] = '0; pwdata[k] = '0; pstrb[k] = '0;
            model_reset(k);
        end
        // Bus activity during reset must not reach the outputs.
        psel[0] = 1'b1; penable[0] = 1'b1;
        repeat (3) @(posedge pclk);
        @(negedge pclk);
        chkb("rst.pready", pready[0], 1'b0);
        chkb("rst.pslverr", pslverr[0], 1'b0);
        chkw("rst.prdata", prdata[0], 32'h0);
        @(posedge pclk); #1;
        preset = '0; psel = '0; penable = '0;
        for (int k = 0; k < 4; k++) idle_check(k, "post_rst");
        chkw("rst.reg0_id", reg_q[0][31:0], ID);

        // Zero-wait read of the ID register.
        transfer(0, 32'h0, 1'b0, 3'b000, 4'h0, 32'h0, "rd_id");
        idle_check(0, "rd_id");

        // WAIT=3 partial-strobe write, then read back.
        transfer(2, 32'h8, 1'b1, 3'b001, 4'b0101, 32'h1122_3344, "wr_strb");
        idle_check(2, "wr_strb");
        chkw("wr_strb.reg2", reg_q[2][64 +: 32], 32'h0022_0044);
        transfer(2, 32'h8, 1'b0, 3'b000, 4'h0, 32'h0, "rd_strb");
        idle_check(2, "rd_strb");

        // Error decode: reg 0, out of range, misaligned, unprivileged last reg.
        transfer(0, 32'h0,            1'b1, 3'b001, 4'hF, 32'hFFFF_FFFF, "err_reg0");
        transfer(0, 32'(NREG * 4),    1'b1, 3'b001, 4'hF, 32'hFFFF_FFFF, "err_range");
        transfer(0, 32'h6,            1'b1, 3'b001, 4'hF, 32'hFFFF_FFFF, "err_misal");
        transfer(0, 32'((NREG-1)*4),  1'b1, 3'b000, 4'hF, 32'h7777_7777, "err_unpriv");
        idle_check(0, "err_all");
        transfer(0, 32'((NREG-1)*4),  1'b1, 3'b001, 4'hF, 32'h7777_7777, "wr_priv");
        transfer(0, 32'hC,            1'b1, 3'b000, 4'h0, 32'h9999_9999, "wr_nostrb");
        idle_check(0, "wr_priv");
        chkw("wr_priv.reg7", reg_q[0][(NREG-1)*32 +: 32], 32'h7777_7777);

        // Back-to-back write then read with no idle cycle.
        transfer(1, 32'h4, 1'b1, 3'b001, 4'hF, 32'hDEAD_BEEF, "b2b_wr");
        transfer(1, 32'h4, 1'b0, 3'b000, 4'h0, 32'h0, "b2b_rd");
        idle_check(1, "b2b");

        // Abort by dropping psel in the first access cycle.
        psel[1] = 1'b1; penable[1] = 1'b0; paddr[1] = 32'hC; pwrite[1] = 1'b1;
        pprot[1] = 3'b001; pstrb[1] = 4'hF; pwdata[1] = 32'h5555_5555;
        @(posedge pclk); #1;
        psel[1] = 1'b0;
        @(negedge pclk);
        chkb("abort.pready", pready[1], 1'b0);
        @(posedge pclk); #1;
        m_perr[1] = 1'b1;
        idle_check(1, "abort");
        proto_clr[1] = 1'b1;
        @(posedge pclk); #1;
        proto_clr[1] = 1'b0; m_perr[1] = 1'b0;
        @(negedge pclk);
        chkb("clr1.proto_err", proto_err[1], 1'b0);
        // Abort by penable low while psel stays high in the access phase.
        @(posedge pclk); #1;
        psel[1] = 1'b1; penable[1] = 1'b0;
        @(posedge pclk); #1;
        @(negedge pclk);
        chkb("abort_en.pready", pready[1], 1'b0);
        @(posedge pclk); #1;
        psel[1] = 1'b0;
        m_perr[1] = 1'b1;
        @(negedge pclk);
        chkb("abort_en.proto_err", proto_err[1], 1'b1);
        // A new setup may have started in the cycle after the abort; let it abort too.
        @(posedge pclk); #1;
        proto_clr[1] = 1'b1;
        @(posedge pclk); #1;
        proto_clr[1] = 1'b0; m_perr[1] = 1'b0;
        idle_check(1, "abort_en");
        // penable without setup, then set-over-clear priority, then clear.
        psel[1] = 1'b1; penable[1] = 1'b1;
        @(posedge pclk); #1;
        psel[1] = 1'b0; penable[1] = 1'b0;
        @(negedge pclk);
        chkb("stray.proto_err", proto_err[1], 1'b1);
        @(posedge pclk); #1;
        psel[1] = 1'b1; penable[1] = 1'b1; proto_clr[1] = 1'b1;
        @(posedge pclk); #1;
        psel[1] = 1'b0; penable[1] = 1'b0; proto_clr[1] = 1'b0;
        @(negedge pclk);
        chkb("prio.proto_err", proto_err[1], 1'b1);
        @(posedge pclk); #1;
        proto_clr[1] = 1'b1;
        @(posedge pclk); #1;
        proto_clr[1] = 1'b0;
        @(negedge pclk);
        chkb("clr2.proto_err", proto_err[1], 1'b0);
        @(posedge pclk); #1;

        // Reset in the middle of a WAIT=4 write.
        transfer(3, 32'h10, 1'b1, 3'b001, 4'hF, 32'hCAFE_F00D, "pre_rst");
        idle_check(3, "pre_rst");
        psel[3] = 1'b1; penable[3] = 1'b0; paddr[3] = 32'h8; pwrite[3] = 1'b1;
        pprot[3] = 3'b001; pstrb[3] = 4'hF; pwdata[3] = 32'h1234_5678;
        @(posedge pclk); #1;
        penable[3] = 1'b1;
        @(negedge pclk);
        chkb("mid_rst.a1_pready", pready[3], 1'b0);
        @(posedge pclk); #1;
        preset[3] = 1'b1;
        @(negedge pclk);
        chkb("mid_rst.pready", pready[3], 1'b0);
        chkw("mid_rst.prdata", prdata[3], 32'h0);
        @(posedge pclk); #1;
        preset[3] = 1'b0; psel[3] = 1'b0; penable[3] = 1'b0;
        model_reset(3);
        for (int c = 0; c < 6; c++) begin
            @(negedge pclk);
            chkb("mid_rst.after_pready", pready[3], 1'b0);
            @(posedge pclk); #1;
        end
        idle_check(3, "mid_rst");
        chkw("mid_rst.reg2", reg_q[3][64 +: 32], 32'h0);
        transfer(3, 32'h0, 1'b0, 3'b000, 4'h0, 32'h0, "rst_rd_id");
        transfer(3, 32'h8, 1'b0, 3'b000, 4'h0, 32'h0, "rst_rd_r2");
        idle_check(3, "rst_rd");

        // Random transfers on every instance.
        for (int k = 0; k < 4; k++) begin
            for (int n = 0; n < 60; n++) begin
                case ($urandom_range(0, 9))
                    0:       a = $urandom_range(0, 40);
                    1:       a = $urandom;
                    default: a = 32'($urandom_range(0, NREG - 1) * 4);
                endcase
                transfer(k, a, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                         4'($urandom_range(0, 15)), $urandom, "rnd");
                if ($urandom_range(0, 1) == 0) idle_check(k, "rnd");
            end
            idle_check(k, "rnd_end");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/apb_reg_completer.md
Name: apb_reg_completer

Overview:
- APB completer (slave-side endpoint) sitting on one `slv_*` port of apb_fabric.
- Decodes each APB transfer against a bank of NREG DATA-wide registers.
- Inserts WAIT programmable wait states per transfer and signals PSLVERR for illegal accesses.
- Drives the register contents out to local logic and flags APB protocol violations from the requester side.

Parameters:
- ADDR, 32, paddr width.
- DATA, 32, pwdata/prdata width (8, 16 or 32).
- NREG, 8, number of registers (2..64); register i lives at byte offset BASE + i*(DATA/8).
- BASE, 0, byte address of register 0; must be aligned to NREG*(DATA/8).
- WAIT, 0, wait states inserted in every access phase (0..15).
- ID, 32'hA5B0_0001, read-only reset/constant value of register 0.

Ports:
- pclk  in  1  clock
- preset  in  1  synchronous active-high reset
- psel  in  1  select from fabric
- penable  in  1  access phase
- pprot  in  3  protection; bit0 = privileged
- paddr  in  ADDR  byte address
- pwrite  in  1  1 = write
- pstrb  in  DATA/8  write byte strobes
- pwdata  in  DATA  write data
- prdata  out  DATA  read data
- pslverr  out  1  transfer error
- pready  out  1  transfer completion
- reg_q  out  NREG*DATA  flattened register contents, reg i at [i*DATA +: DATA]
- proto_err  out  1  sticky protocol-violation flag
- proto_clr  in  1  clears proto_err

Behaviour:
- Reset (synchronous, preset=1 at rising pclk):
  - FSM to IDLE; wait counter 0.
  - Register 0 = ID; registers 1..NREG-1 = 0.
  - proto_err = 0.
  - Outputs while in reset: prdata 0, pslverr 0, pready 0.
  - Reset asserted mid-transfer aborts the transfer with no register write and no pready pulse.
- FSM states: IDLE, ACCESS.
- IDLE:
  - psel=1, penable=0 (setup phase): capture paddr, pwrite, pstrb, pwdata, pprot; load wait counter with WAIT; next state ACCESS.
  - psel=1, penable=1 with no preceding setup: set proto_err; stay IDLE.
- ACCESS:
  - Counter is nonzero: pready=0; counter decrements each cycle.
  - Counter is 0: pready=1 combinationally in that cycle (the completion cycle). At the end of that cycle go to IDLE; a back-to-back setup in the next cycle is accepted.
  - WAIT=0 gives a zero-wait transfer: pready=1 in the first access cycle.
  - Total transfer length is 2+WAIT cycles.
- Captured inputs: the fabric holds them stable; the block uses the captured copies only.
- Abort in ACCESS: if psel drops, or penable is 0 while psel=1, before completion:
  - set proto_err, return to IDLE, no write, pready stays 0.
- Error decode, evaluated on captured values. pslverr=1 in the completion cycle if any of:
  - address outside [BASE, BASE+NREG*DATA/8);
  - address not aligned to DATA/8;
  - write to register 0;
  - write with pprot[0]=0 to register NREG-1 (privileged-only register).
- Errored writes modify nothing; errored reads return prdata=0.
- Write: on the rising edge ending a non-error completion cycle, each byte b of the target register is updated from pwdata where pstrb[b]=1. pstrb=0 is a legal no-op write with pslverr=0.
- Read: prdata = target register in the completion cycle; prdata=0 in every other cycle. A read of a register written by the immediately preceding transfer returns the new value.
- pslverr is 0 in every cycle other than a completion cycle.
- proto_err:
  - set has priority over proto_clr in the same cycle;
  - reg_q updates one cycle after the write edge (registered).
- pready is 0 in IDLE.

Test Plan:
- Reset, then read offset 0 (WAIT=0) -> pready=1 in the 2nd cycle, prdata=32'hA5B0_0001, pslverr=0; all other reg_q slices 0.
- WAIT=3, write reg 2 with pwdata=32'h1122_3344, pstrb=4'b0101 -> pready low for 3 access cycles, high on the 4th; reg 2 = 32'h0022_0044. A following read returns the same value.
- Write reg 0, write offset NREG*4, write offset 0x6 (misaligned) -> pslverr=1 on each completion, reg_q unchanged. Write reg NREG-1 with pprot=3'b000 -> pslverr=1; with pprot=3'b001 -> write succeeds.
- Back-to-back: write reg 1 = 32'hDEAD_BEEF, then setup a read of reg 1 in the very next cycle -> second transfer accepted with no idle gap; prdata=32'hDEAD_BEEF.
- WAIT=2: drop psel in the 1st access cycle -> proto_err=1, reg unchanged, no pready pulse. Assert penable without setup -> proto_err set. proto_clr -> proto_err=0.
- Assert preset during the access phase of a write with WAIT=4 -> no write occurs, pready never 1. The next clean transfer completes normally and reg 0 reads ID.
